// File: rtl/key_char_buffer_if.sv
// Bundle between the PS/2 decoder/consumer side and key_char_buffer.
// The decoder event inputs and the character FIFO outputs share one interface.
interface key_char_buffer_if #(
    parameter int AW = 4
) ();
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         pop;
    logic [7:0]   char_out;
    logic         char_valid;
    logic         full;
    logic [AW:0]  count;
    logic         overflow;

    modport master (
        output key_down, last_change, key_valid, pop,
        input  char_out, char_valid, full, count, overflow
    );

    modport slave (
        input  key_down, last_change, key_valid, pop,
        output char_out, char_valid, full, count, overflow
    );
endinterface

// File: rtl/key_char_buffer.sv
// Translates PS/2 make events into ASCII (Shift-aware) and queues them in a
// show-ahead FIFO drained by pop; break and unmapped events are discarded.
module key_char_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input logic            clk,
    input logic            rst,
    key_char_buffer_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic       shift;
    logic       make;
    logic       letter;
    logic [4:0] idx;
    logic       xl_vld;
    logic [7:0] xl_char;

    logic          pend_vld_q, pend_vld_d;
    logic [7:0]    pend_char_q, pend_char_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];
    logic          pop_acc;
    logic          wr_en;

    always_comb begin
        shift   = bus.key_down[9'h012] | bus.key_down[9'h059];
        make    = bus.key_valid & bus.key_down[bus.last_change];
        letter  = 1'b0;
        idx     = 5'd0;
        xl_vld  = 1'b0;
        xl_char = 8'h00;
        case (bus.last_change)
            9'h01C: {letter, idx} = {1'b1, 5'd0};
            9'h032: {letter, idx} = {1'b1, 5'd1};
            9'h021: {letter, idx} = {1'b1, 5'd2};
            9'h023: {letter, idx} = {1'b1, 5'd3};
            9'h024: {letter, idx} = {1'b1, 5'd4};
            9'h02B: {letter, idx} = {1'b1, 5'd5};
            9'h034: {letter, idx} = {1'b1, 5'd6};
            9'h033: {letter, idx} = {1'b1, 5'd7};
            9'h043: {letter, idx} = {1'b1, 5'd8};
            9'h03B: {letter, idx} = {1'b1, 5'd9};
            9'h042: {letter, idx} = {1'b1, 5'd10};
            9'h04B: {letter, idx} = {1'b1, 5'd11};
            9'h03A: {letter, idx} = {1'b1, 5'd12};
            9'h031: {letter, idx} = {1'b1, 5'd13};
            9'h044: {letter, idx} = {1'b1, 5'd14};
            9'h04D: {letter, idx} = {1'b1, 5'd15};
            9'h015: {letter, idx} = {1'b1, 5'd16};
            9'h02D: {letter, idx} = {1'b1, 5'd17};
            9'h01B: {letter, idx} = {1'b1, 5'd18};
            9'h02C: {letter, idx} = {1'b1, 5'd19};
            9'h03C: {letter, idx} = {1'b1, 5'd20};
            9'h02A: {letter, idx} = {1'b1, 5'd21};
            9'h01D: {letter, idx} = {1'b1, 5'd22};
            9'h022: {letter, idx} = {1'b1, 5'd23};
            9'h035: {letter, idx} = {1'b1, 5'd24};
            9'h01A: {letter, idx} = {1'b1, 5'd25};
            9'h045: {xl_vld, xl_char} = {1'b1, 8'h30};
            9'h016: {xl_vld, xl_char} = {1'b1, 8'h31};
            9'h01E: {xl_vld, xl_char} = {1'b1, 8'h32};
            9'h026: {xl_vld, xl_char} = {1'b1, 8'h33};
            9'h025: {xl_vld, xl_char} = {1'b1, 8'h34};
            9'h02E: {xl_vld, xl_char} = {1'b1, 8'h35};
            9'h036: {xl_vld, xl_char} = {1'b1, 8'h36};
            9'h03D: {xl_vld, xl_char} = {1'b1, 8'h37};
            9'h03E: {xl_vld, xl_char} = {1'b1, 8'h38};
            9'h046: {xl_vld, xl_char} = {1'b1, 8'h39};
            9'h029: {xl_vld, xl_char} = {1'b1, 8'h20};
            9'h05A: {xl_vld, xl_char} = {1'b1, 8'h0D};
            9'h15A: {xl_vld, xl_char} = {1'b1, 8'h0D};
            9'h066: {xl_vld, xl_char} = {1'b1, 8'h08};
            default: ;
        endcase
        if (letter) begin
            xl_vld  = 1'b1;
            xl_char = (shift ? 8'h41 : 8'h61) + {3'b000, idx};
        end
        pend_vld_d  = make & xl_vld;
        pend_char_d = xl_char;
    end

    // A full FIFO still takes the write when a pop frees a slot in the same edge.
    always_comb begin
        pop_acc  = bus.pop & (count_q != '0);
        wr_en    = pend_vld_q & ((count_q != FULL_CNT) | pop_acc);
        wr_ptr_d = wr_en   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en, pop_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (pend_vld_q & ~wr_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q  <= 1'b0;
            pend_char_q <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_char_q <= pend_char_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_ptr_q] <= pend_char_q;
    end

    assign bus.char_valid = (count_q != '0);
    assign bus.char_out   = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.full       = (count_q == FULL_CNT);
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_key_char_buffer.sv
// Bench for key_char_buffer: directed scenarios with literal expectations plus
// randomized key traffic checked every cycle against a queue-based model.
module tb_key_char_buffer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk;
    logic rst;
    key_char_buffer_if #(.AW(AW)) bus ();

    key_char_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    byte unsigned lcode [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned dcode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                 8'h3D, 8'h3E, 8'h46};
    logic [8:0] pool [24] = '{9'h01C, 9'h032, 9'h035, 9'h01A, 9'h015, 9'h04D,
                              9'h045, 9'h016, 9'h046, 9'h03E, 9'h029, 9'h05A,
                              9'h066, 9'h15A, 9'h174, 9'h11C, 9'h012, 9'h059,
                              9'h076, 9'h00D, 9'h05A, 9'h024, 9'h03A, 9'h02E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Translation from the key tables, returns {valid, char}.
    function automatic logic [8:0] ref_xlat(input logic [511:0] kd, input logic [8:0] lc,
                                            input logic kv);
        logic sh;
        sh = kd[9'h012] | kd[9'h059];
        if (!kv || !kd[lc]) return 9'h000;
        if (lc[8]) return (lc == 9'h15A) ? {1'b1, 8'h0D} : 9'h000;
        for (int i = 0; i < 26; i++)
            if (lc[7:0] == lcode[i]) return {1'b1, 8'((sh ? 65 : 97) + i)};
        for (int i = 0; i < 10; i++)
            if (lc[7:0] == dcode[i]) return {1'b1, 8'(48 + i)};
        case (lc[7:0])
            8'h29:   return {1'b1, 8'h20};
            8'h5A:   return {1'b1, 8'h0D};
            8'h66:   return {1'b1, 8'h08};
            default: return 9'h000;
        endcase
    endfunction

    byte unsigned mq [$];
    bit           m_ovf  = 1'b0;
    bit           m_pvld = 1'b0;
    byte unsigned m_pch  = 8'h00;

    initial begin
        logic [8:0] x;
        bit pa;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_pvld = 1'b0;
            end else begin
                pa = bus.pop && (mq.size() > 0);
                if (pa) void'(mq.pop_front());
                if (m_pvld) begin
                    if (mq.size() < DEPTH) mq.push_back(m_pch);
                    else m_ovf = 1'b1;
                end
                x = ref_xlat(bus.key_down, bus.last_change, bus.key_valid);
                m_pvld = x[8];
                m_pch  = x[7:0];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("char_valid", 32'(bus.char_valid), 32'(mq.size() != 0));
                chk("char_out", 32'(bus.char_out), 32'(mq.size() != 0 ? mq[0] : 8'h00));
                chk("count", 32'(bus.count), 32'(mq.size()));
                chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
                chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.pop       = 1'b0;
    endtask

    task automatic make_ev(input logic [8:0] code);
        bus.key_down[code] = 1'b1;
        bus.last_change    = code;
        bus.key_valid      = 1'b1;
        cyc();
    endtask

    task automatic brk_ev(input logic [8:0] code);
        bus.key_down[code] = 1'b0;
        bus.last_change    = code;
        bus.key_valid      = 1'b1;
        cyc();
    endtask

    task automatic pop_cyc();
        bus.pop = 1'b1;
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.key_down    = '0;
        bus.last_change = '0;
        bus.key_valid   = 1'b0;
        bus.pop         = 1'b0;
        do_reset();
        chk_en = 1'b1;

        @(negedge clk);
        chk("rst char_valid", 32'(bus.char_valid), 32'd0);
        chk("rst char_out", 32'(bus.char_out), 32'h00);
        chk("rst count", 32'(bus.count), 32'd0);
        chk("rst full", 32'(bus.full), 32'd0);
        chk("rst overflow", 32'(bus.overflow), 32'd0);

        // lowercase letter, 2-clock latency
        make_ev(9'h01C);
        @(negedge clk);
        chk("lat1 char_valid", 32'(bus.char_valid), 32'd0);
        cyc();
        @(negedge clk);
        chk("a char_valid", 32'(bus.char_valid), 32'd1);
        chk("a char_out", 32'(bus.char_out), 32'h61);
        chk("a count", 32'(bus.count), 32'd1);
        pop_cyc();
        @(negedge clk);
        chk("a pop char_valid", 32'(bus.char_valid), 32'd0);
        chk("a pop count", 32'(bus.count), 32'd0);

        // shift + letter, digit, break
        bus.key_down[9'h012] = 1'b1;
        make_ev(9'h035);
        make_ev(9'h016);
        brk_ev(9'h035);
        cyc();
        cyc();
        @(negedge clk);
        chk("Y count", 32'(bus.count), 32'd2);
        chk("Y char_out", 32'(bus.char_out), 32'h59);
        pop_cyc();
        @(negedge clk);
        chk("digit1 char_out", 32'(bus.char_out), 32'h31);
        pop_cyc();
        bus.key_down = '0;

        // specials and unmapped
        make_ev(9'h029);
        make_ev(9'h066);
        make_ev(9'h15A);
        make_ev(9'h174);
        make_ev(9'h012);
        cyc();
        cyc();
        @(negedge clk);
        chk("special count", 32'(bus.count), 32'd3);
        chk("space", 32'(bus.char_out), 32'h20);
        pop_cyc();
        @(negedge clk);
        chk("bksp", 32'(bus.char_out), 32'h08);
        pop_cyc();
        @(negedge clk);
        chk("kp enter", 32'(bus.char_out), 32'h0D);
        pop_cyc();
        bus.key_down = '0;

        // overflow
        for (int i = 0; i < DEPTH + 2; i++) make_ev(9'h01C);
        cyc();
        cyc();
        @(negedge clk);
        chk("ovf count", 32'(bus.count), 32'd16);
        chk("ovf full", 32'(bus.full), 32'd1);
        chk("ovf flag", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("drain a", 32'(bus.char_out), 32'h61);
            pop_cyc();
        end
        @(negedge clk);
        chk("drained char_valid", 32'(bus.char_valid), 32'd0);
        chk("ovf sticky", 32'(bus.overflow), 32'd1);
        do_reset();
        @(negedge clk);
        chk("ovf cleared", 32'(bus.overflow), 32'd0);

        // simultaneous pop and write at full; write wraps wr_ptr to 0
        for (int i = 0; i < DEPTH; i++) make_ev(9'h01C);
        cyc();
        cyc();
        @(negedge clk);
        chk("sim full", 32'(bus.full), 32'd1);
        make_ev(9'h032);
        bus.pop = 1'b1;
        cyc();
        @(negedge clk);
        chk("sim count", 32'(bus.count), 32'd16);
        chk("sim overflow", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("sim drain", 32'(bus.char_out), (i == DEPTH - 1) ? 32'h62 : 32'h61);
            pop_cyc();
        end
        @(negedge clk);
        chk("sim empty", 32'(bus.count), 32'd0);
        bus.key_down = '0;

        // reset while a character sits in stage 1
        make_ev(9'h01C);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst count", 32'(bus.count), 32'd0);
        chk("midrst char_valid", 32'(bus.char_valid), 32'd0);
        chk("midrst char_out", 32'(bus.char_out), 32'h00);
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        chk("midrst later count", 32'(bus.count), 32'd0);
        bus.key_down = '0;

        // randomized traffic with phases of light and heavy popping
        for (int i = 0; i < 4000; i++) begin
            logic [8:0] code;
            int pop_pct;
            pop_pct = ((i / 400) % 2 == 0) ? 10 : 70;
            if ($urandom_range(0, 99) < 5)
                bus.key_down[($urandom_range(0, 1) == 0) ? 9'h012 : 9'h059] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 60) begin
                code = pool[$urandom_range(0, 23)];
                bus.key_down[code] = ($urandom_range(0, 3) != 0);
                bus.last_change    = code;
                bus.key_valid      = 1'b1;
            end
            bus.pop = ($urandom_range(0, 99) < pop_pct);
            rst     = ($urandom_range(0, 999) < 2);
            cyc();
            rst = 1'b0;
        end
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/key_char_buffer.md
# key_char_buffer

Downstream consumer of the PS/2 keyboard decoder. It watches the decoder's `key_valid` / `last_change` / `key_down` outputs and translates each key-press (make) event into an 8-bit ASCII code, honouring the Shift keys. Translated characters go into a show-ahead FIFO that game/text logic drains with a `pop` strobe. Break events, unmapped keys and most extended keys are discarded.

## Interface
- `DEPTH`, default 16: FIFO depth in characters; power of two, ≥ 2.
- `AW`, default 4: log2(DEPTH).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock; the same clock as the keyboard decoder.
- `rst`  in  1: synchronous, active-high reset.
- `key_down`  in  512: decoder key-state vector; bit `{ext, code}` is 1 while that key is held.
- `last_change`  in  9: `{ext, scan_code}` of the most recent event.
- `key_valid`  in  1: one-cycle strobe from the decoder. `key_down` already reflects the event in the same cycle.
- `pop`  in  1: consumer acknowledges `char_out`.
- `char_out`  out  8: ASCII code at the FIFO head; valid only while `char_valid` = 1.
- `char_valid`  out  1: FIFO not empty.
- `full`  out  1: count == DEPTH.
- `count`  out  AW+1: number of stored characters.
- `overflow`  out  1: sticky flag; a translated character was dropped.

## Operation
- **Event qualification.** When `key_valid` = 1 and `key_down[last_change]` = 1, the event is a make. If `key_down[last_change]` = 0, it is a break and is ignored.
- **Shift.** `shift = key_down[9'h012] | key_down[9'h059]`, sampled in the same cycle as `key_valid`.
- **Letters.** Non-extended codes map as A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
  - Output is 0x61+n (lowercase) when shift = 0.
  - Output is 0x41+n (uppercase) when shift = 1.
- **Digits.** 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46 map to 0x30+n. Shift is ignored for digits.
- **Other non-extended keys.** Space 029 → 0x20; Enter 05A → 0x0D; Backspace 066 → 0x08.
- **Extended keys.** Only keypad Enter 15A → 0x0D is mapped. All other extended codes are dropped.
- **Unmapped makes** (including Shift itself) are dropped silently and have no effect on the FIFO or flags.
- **Stage-1 register.** `pend_vld` and `pend_char` are loaded every cycle from the translation result (`pend_vld` = 0 when nothing qualifies).
- **FIFO write.** When `pend_vld` = 1:
  - If `count < DEPTH`, or `pop` is accepted in the same cycle, `pend_char` is written at `wr_ptr` and `wr_ptr` increments.
  - Otherwise the character is dropped and `overflow` is set to 1.
- **FIFO read.** `pop` is accepted only when `char_valid` = 1; `rd_ptr` then increments. `pop` on an empty FIFO has no effect.
- **Pointers.** Both pointers are AW bits and wrap modulo DEPTH. `count` is kept as a separate AW+1-bit counter:
  - +1 on write only;
  - −1 on accepted pop only;
  - unchanged when both occur in the same cycle.
- **Empty-FIFO race.** A simultaneous write and pop on an empty FIFO cannot happen, because pop is not accepted when empty. The write proceeds normally.
- **Reset values.** `rst` clears `pend_vld`, both pointers, `count` and `overflow`. After reset:
  - `char_valid` = 0, `full` = 0, `count` = 0, `overflow` = 0;
  - `char_out` = 0x00 (the head is muxed to 0 when empty);
  - storage contents are don't-care.
- **Reset mid-operation.** A character in the stage-1 register is discarded.

## Timing
- Make event with `key_valid` sampled at edge E0: `pend_vld` is high after E0, the write occurs at E1, and `char_valid` / `char_out` are visible after E1. Latency is 2 clocks.
- Back-to-back `key_valid` on consecutive cycles is accepted at full rate: one character per clock.
- Show-ahead FIFO: `char_out` is combinational from storage[`rd_ptr`] and changes in the cycle after an accepted pop.
- `full`, `char_valid` and `count` are decoded from registered `count` and are glitch-free relative to `clk`.
- `overflow` rises in the cycle after the dropping edge and stays high until `rst`.

## Test plan
- **Lowercase letter.** Reset, then a make on `last_change` = 0x01C with no shift. Required: after 2 edges `char_valid` = 1, `char_out` = 0x61, `count` = 1. Then `pop` for one cycle; required: `char_valid` = 0, `count` = 0.
- **Shifted letter, digit, break.** Hold `key_down[0x012]` = 1, then make 0x035 (Y). Required: `char_out` = 0x59. Then make 0x016 with shift held; required: second entry = 0x31. Then a break of 0x035; required: nothing written and `count` = 2.
- **Special and unmapped keys.** Makes on 0x029, 0x066, 0x15A, 0x174, 0x012. Required: FIFO holds exactly 0x20, 0x08, 0x0D in order, `count` = 3.
- **Overflow.** Push DEPTH+2 (18) make events of 'a' with no pops. Required: `count` = 16, `full` = 1, `overflow` = 1. Draining returns 16 × 0x61, then `char_valid` = 0. `overflow` stays 1 until `rst`.
- **Simultaneous pop and write at full.** With the FIFO full, assert `pop` in the cycle `pend_vld` = 1 for 'b'. Required: `count` stays 16, `overflow` unchanged at 0, and the last drained entry = 0x62. Include at least one pointer wrap.
- **Reset mid-operation.** Assert `rst` in the cycle after a make (while `pend_vld` = 1). Required: next cycle `count` = 0, `char_valid` = 0, `char_out` = 0x00, and nothing is written afterwards.
